// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared types for the single-port RAM arbiter: the sequencing FSM state,
// the grant identity carried through a transaction, and the read-data fill
// value returned when a read is completed by the WAIT timeout.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_DL   = 2'd1,
    G_VID  = 2'd2,
    G_CPU  = 2'd3
  } grant_e;

  // Sliced down to DW bits by the user, so DW up to 64 is supported.
  localparam logic [63:0] RDATA_ERR_FILL = '1;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick
// Combinational priority selection for the RAM arbiter.
// Ports:
//   dl_req, vid_req, cpu_req : requester levels sampled in IDLE
//   streak_max               : video streak has reached its limit
//   grant                    : winning requester (G_NONE when nobody asks)
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic   dl_req,
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   streak_max,
  output grant_e grant
);

  always_comb begin
    grant = G_NONE;
    if (dl_req) begin
      grant = G_DL;
    end else if (vid_req && !(cpu_req && streak_max)) begin
      // Video yields only when the CPU is actually waiting and video
      // has already taken its allowed run of consecutive grants.
      grant = G_VID;
    end else if (cpu_req) begin
      grant = G_CPU;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one downstream memory port between the download, video and CPU
// requesters. One transaction at a time: IDLE (arbitrate + snapshot),
// ISSUE (command strobe), WAIT (for mem_ready or timeout), DONE (ack).
// Ports:
//   clk_sys, reset                       : clock, synchronous active-high reset
//   dl_req/dl_addr/dl_data, dl_ack       : download writes
//   vid_req/vid_addr, vid_ack            : video reads
//   cpu_req/cpu_we/cpu_addr/cpu_wdata,
//   cpu_ack                              : CPU reads and writes
//   rdata, err                           : read result (held), timeout pulse
//   mem_req/mem_we/mem_addr/mem_wdata,
//   mem_ready/mem_rdata                  : downstream memory port
//   busy                                 : high outside IDLE
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW      = 23,
  parameter int DW      = 8,
  parameter int VID_MAX = 2,
  parameter int TIMEOUT = 64
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int SW = $clog2(VID_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(VID_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  grant_e        grant_q, grant_d;
  grant_e        grant_pick;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;

  ram_arb_pick u_pick (
    .dl_req     (dl_req),
    .vid_req    (vid_req),
    .cpu_req    (cpu_req),
    .streak_max (streak_q == STREAK_MAX),
    .grant      (grant_pick)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    streak_d = streak_q;
    tmo_d    = tmo_q;

    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        // The streak only counts video wins that actually held off a
        // waiting CPU; any CPU win or an absent CPU request resets it.
        if (!cpu_req || grant_pick == G_CPU) begin
          streak_d = '0;
        end else if (grant_pick == G_VID && streak_q != STREAK_MAX) begin
          streak_d = streak_q + SW'(1);
        end

        if (grant_pick != G_NONE) begin
          state_d = ISSUE;
          grant_d = grant_pick;
          case (grant_pick)
            G_DL: begin
              we_d    = 1'b1;
              addr_d  = dl_addr;
              wdata_d = dl_data;
            end
            G_VID: begin
              we_d    = 1'b0;
              addr_d  = vid_addr;
              wdata_d = '0;
            end
            G_CPU: begin
              we_d    = cpu_we;
              addr_d  = cpu_addr;
              wdata_d = cpu_wdata;
            end
            default: ;
          endcase
        end
      end

      ISSUE: begin
        state_d = WAIT;
        tmo_d   = '0;
      end

      WAIT: begin
        // mem_ready is checked first so a response on the last allowed
        // cycle still completes normally.
        if (mem_ready) begin
          state_d = DONE;
          if (!we_q) rdata_d = mem_rdata;
        end else if (tmo_q == TMO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) rdata_d = RDATA_ERR_FILL[DW-1:0];
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= G_NONE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      streak_q <= streak_d;
      tmo_q    <= tmo_d;
    end
  end

  assign dl_ack    = (state_q == DONE) && (grant_q == G_DL);
  assign vid_ack   = (state_q == DONE) && (grant_q == G_VID);
  assign cpu_ack   = (state_q == DONE) && (grant_q == G_CPU);
  assign err       = (state_q == DONE) && err_q;
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Randomised and directed stimulus for ram_arbiter. The stimulus side works
// out, per transaction, the winner, issue cycle, ack cycle, read data and
// err from the arbitration rules and the chosen memory latency, and queues
// them; a negedge monitor pops and compares whenever the DUT strobes
// mem_req or an ack.
module tb_ram_arbiter;

  localparam int AW      = 23;
  localparam int DW      = 8;
  localparam int VID_MAX = 2;
  localparam int TIMEOUT = 64;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic [2:0]    rq      = '0;      // [0] dl, [1] vid, [2] cpu
  logic [AW-1:0] ra [3];
  logic [DW-1:0] rd [3];
  logic          cpu_we_r  = 1'b0;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  logic          dl_ack, vid_ack, cpu_ack, err, mem_req, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  ram_arbiter #(.AW(AW), .DW(DW), .VID_MAX(VID_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .dl_req    (rq[0]),
    .dl_addr   (ra[0]),
    .dl_data   (rd[0]),
    .dl_ack    (dl_ack),
    .vid_req   (rq[1]),
    .vid_addr  (ra[1]),
    .vid_ack   (vid_ack),
    .cpu_req   (rq[2]),
    .cpu_we    (cpu_we_r),
    .cpu_addr  (ra[2]),
    .cpu_wdata (rd[2]),
    .cpu_ack   (cpu_ack),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [2:0]    acks;   // {dl, vid, cpu}
    logic [DW-1:0] rdata;
    logic          err;
  } ack_t;

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } iss_t;

  ack_t ack_q[$];
  iss_t iss_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: streak of video wins over a waiting CPU, and the
  // read data the DUT should currently be presenting.
  int            streak_m = 0;
  logic [DW-1:0] hold_m   = '0;
  logic [DW-1:0] hold_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every command strobe and every ack against the queues.
  always @(negedge clk_sys) begin
    ack_t a;
    iss_t s;
    if (reset) begin
      hold_rdata = '0;
    end else begin
      if (mem_req) begin
        if (iss_q.size() == 0) begin
          chk("mem_req_unexpected", mem_req, 1'b0);
        end else begin
          s = iss_q.pop_front();
          chk("issue_cycle", cyc, s.cyc);
          chk("issue_we", mem_we, s.we);
          chk("issue_addr", mem_addr, s.addr);
          if (s.we) chk("issue_wdata", mem_wdata, s.wdata);
        end
      end
      if (dl_ack | vid_ack | cpu_ack) begin
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", {dl_ack, vid_ack, cpu_ack}, 3'b000);
        end else begin
          a = ack_q.pop_front();
          chk("ack_who", {dl_ack, vid_ack, cpu_ack}, a.acks);
          chk("ack_cycle", cyc, a.cyc);
          chk("ack_rdata", rdata, a.rdata);
          chk("ack_err", err, a.err);
          chk("ack_busy", busy, 1'b1);
          hold_rdata = a.rdata;
        end
      end else begin
        chk("err_without_ack", err, 1'b0);
        chk("rdata_hold", rdata, hold_rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic raise(input int who, input logic we);
    rq[who] = 1'b1;
    ra[who] = AW'($urandom);
    rd[who] = DW'($urandom);
    if (who == 2) cpu_we_r = we;
  endtask

  // Winner from the priority rules: download first, then video unless the
  // CPU is waiting and video already had VID_MAX wins in a row.
  function automatic int pick_model();
    if (rq[0]) return 0;
    if (rq[1] && !(rq[2] && streak_m == VID_MAX)) return 1;
    if (rq[2]) return 2;
    return -1;
  endfunction

  task automatic idle_step();
    streak_m  = 0;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = DW'($urandom);
    step();
  endtask

  // Called in a cycle where the DUT is idle and at least one req is high.
  // lat = WAIT cycles before mem_ready (0 = first WAIT cycle);
  // lat >= TIMEOUT means memory never answers.
  task automatic txn(input int lat, input logic [DW-1:0] mdata);
    int         d, w, rc, ack_c;
    logic       we;
    bit         tmo;
    logic [2:0] oh;
    ack_t       a;
    iss_t       s;
    d = cyc;
    w = pick_model();
    if (w < 0) begin
      idle_step();
      return;
    end
    if (!rq[2] || w == 2) streak_m = 0;
    else if (w == 1 && streak_m < VID_MAX) streak_m = streak_m + 1;

    we    = (w == 0) ? 1'b1 : (w == 1) ? 1'b0 : cpu_we_r;
    tmo   = (lat >= TIMEOUT);
    rc    = d + 2 + lat;
    ack_c = tmo ? d + 2 + TIMEOUT : rc + 1;
    if (!we) hold_m = tmo ? '1 : mdata;
    oh = (w == 0) ? 3'b100 : (w == 1) ? 3'b010 : 3'b001;

    s = '{d + 1, we, ra[w], rd[w]};
    iss_q.push_back(s);
    a = '{ack_c, oh, hold_m, tmo};
    ack_q.push_back(a);

    for (int c = d + 1; c <= ack_c + 1; c++) begin
      step();
      if (!tmo && c == rc) begin
        mem_ready = 1'b1;
        mem_rdata = mdata;
      end else if (c == d + 1 || c >= ack_c) begin
        // outside WAIT a stray mem_ready must have no effect
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = DW'($urandom);
      end
    end
    rq[w] = 1'b0;
    chk("busy_idle_after_ack", busy, 1'b0);
  endtask

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return TIMEOUT + 2;
    if (r == 1) return TIMEOUT - 1;
    return $urandom_range(0, 4);
  endfunction

  task automatic reset_mid();
    int   d;
    iss_t s;
    rq = '0;
    raise(2, 1'b0);
    d = cyc;
    mem_ready = 1'b0;
    s = '{d + 1, 1'b0, ra[2], rd[2]};
    iss_q.push_back(s);
    repeat (4) step();          // cycle d+4, DUT in WAIT
    reset = 1'b1;
    step();                     // cycle d+5
    reset     = 1'b0;
    rq[2]     = 1'b0;
    mem_ready = 1'b1;           // late response for the abandoned access
    mem_rdata = 8'hA5;
    @(negedge clk_sys);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_no_ack", {dl_ack, vid_ack, cpu_ack}, 3'b000);
    step();
    mem_ready = 1'b0;
    @(negedge clk_sys);
    chk("rst_late_ready_busy", busy, 1'b0);
    chk("rst_late_ready_no_ack", {dl_ack, vid_ack, cpu_ack}, 3'b000);
    streak_m = 0;
    hold_m   = '0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ra[i] = '0;
      rd[i] = '0;
    end
    step();
    step();
    @(negedge clk_sys);
    chk("rst_acks", {dl_ack, vid_ack, cpu_ack}, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_req0", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_busy0", busy, 1'b0);
    step();
    reset = 1'b0;

    // all three at once: download first, then the others
    raise(0, 1'b1);
    raise(1, 1'b0);
    raise(2, 1'b0);
    txn(1, DW'($urandom));

    // video and CPU both held: vid, vid, cpu, vid, vid, cpu
    for (int i = 0; i < 6; i++) begin
      if (!rq[1]) raise(1, 1'b0);
      if (!rq[2]) raise(2, 1'b0);
      txn(1, DW'($urandom));
    end
    while (rq != 3'b000) txn(0, DW'($urandom));

    // CPU read of 0x004000 returning 0x5A, then a write leaves rdata alone
    raise(2, 1'b0);
    ra[2] = 23'h004000;
    txn(2, 8'h5A);
    repeat (3) idle_step();
    raise(0, 1'b1);
    txn(0, DW'($urandom));

    // read timeout, ready on the final cycle, write timeout
    raise(2, 1'b0);
    txn(TIMEOUT + 10, DW'($urandom));
    raise(1, 1'b0);
    txn(TIMEOUT - 1, 8'h12);
    raise(0, 1'b1);
    txn(TIMEOUT, DW'($urandom));

    // reset during WAIT, then a normal transaction
    reset_mid();
    raise(2, 1'b0);
    txn(1, 8'h3C);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      if (!rq[0] && $urandom_range(0, 3) == 0) raise(0, 1'b1);
      if (!rq[1] && $urandom_range(0, 2) != 0) raise(1, 1'b0);
      if (!rq[2] && $urandom_range(0, 2) != 0) raise(2, 1'($urandom_range(0, 1)));
      if (rq == 3'b000) idle_step();
      else txn(rand_lat(), DW'($urandom));
    end
    for (int i = 0; i < 3 && rq != 3'b000; i++) txn(0, DW'($urandom));

    repeat (4) idle_step();
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("issue_queue_drained", iss_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
